// File: rtl/hack_io_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hack_io_pkg
// Description : Shared types and constants for the Hack memory-mapped I/O.
// Revision    : 1.0 - initial release
// ============================================================================
package hack_io_pkg;

    localparam logic [15:0] KBD_ADDR = 16'h6000;

    typedef logic [15:0] hack_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2
    } kbd_state_t;

    function automatic logic is_kbd_write(input logic wr, input hack_word_t addr);
        return wr && (addr == KBD_ADDR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hack_kbd_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : hack_kbd_controller_if
// Description : Key-event handshake, CPU ack decode inputs and KBD outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface hack_kbd_controller_if #(
    parameter int DEPTH = 8
) ();
    import hack_io_pkg::*;

    logic                   ev_valid;
    logic                   ev_ready;
    hack_word_t             ev_code;
    logic                   ev_press;
    hack_word_t             addressM;
    logic                   writeM;
    hack_word_t             kbd_out;
    logic [$clog2(DEPTH):0] fifo_level;

    modport master (
        output ev_valid, ev_code, ev_press, addressM, writeM,
        input  ev_ready, kbd_out, fifo_level
    );

    modport slave (
        input  ev_valid, ev_code, ev_press, addressM, writeM,
        output ev_ready, kbd_out, fifo_level
    );
endinterface
`default_nettype wire

// File: rtl/kbd_fifo.sv
`default_nettype none
// ============================================================================
// Module      : kbd_fifo
// Description : Synchronous FIFO with occupancy count; head is shown unregistered.
// Revision    : 1.0 - initial release
// ============================================================================
module kbd_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  wire logic                     clock,
    input  wire logic                     reset,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         din_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         dout_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             do_push_w, do_pop_w;

    assign full_o    = (level_q == LW'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign dout_o    = mem_q[rd_ptr_q];
    assign do_push_w = push_i && !full_o;
    assign do_pop_w  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push_w) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push_w, do_pop_w})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: the count alone defines which entries are live.
    always_ff @(posedge clock) begin
        if (do_push_w) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/hack_kbd_controller.sv
`default_nettype none
// ============================================================================
// Module      : hack_kbd_controller
// Description : Buffers key presses and presents each on KBD for a hold window
//               followed by a zero gap. Define KBD_ACK_EN to let a CPU write to
//               KBD end the hold window early.
// Revision    : 1.0 - initial release
// ============================================================================
module hack_kbd_controller
    import hack_io_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int HOLD_CYCLES = 1024,
    parameter int GAP_CYCLES  = 64
) (
    input  wire logic          clock,
    input  wire logic          reset,
    hack_kbd_controller_if.slave bus
);
    localparam int LW   = $clog2(DEPTH) + 1;
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_SHOW = SHOW;
    localparam logic [1:0] S_GAP  = GAP;

    logic [1:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    hack_word_t    cur_q, cur_d;
    hack_word_t    kbd_out_q, kbd_out_d;

    logic          push_w, pop_w, full_w, empty_w, ack_w;
    hack_word_t    head_w;
    logic [LW-1:0] level_w;

    assign bus.ev_ready   = !full_w;
    assign bus.fifo_level = level_w;
    assign bus.kbd_out    = kbd_out_q;

    // Releases and code 0 are still handshaken, just never stored.
    assign push_w = bus.ev_valid && !full_w && bus.ev_press && (bus.ev_code != '0);

`ifdef KBD_ACK_EN
    assign ack_w = (state_q == S_SHOW) && is_kbd_write(bus.writeM, bus.addressM);
`else
    logic unused_ack;
    assign unused_ack = ^{bus.addressM, bus.writeM};
    assign ack_w      = 1'b0;
`endif

    kbd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_w),
        .din_i   (bus.ev_code),
        .pop_i   (pop_w),
        .dout_o  (head_w),
        .full_o  (full_w),
        .empty_o (empty_w),
        .level_o (level_w)
    );

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        cur_d   = cur_q;
        pop_w   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_w) begin
                    pop_w   = 1'b1;
                    cur_d   = head_w;
                    timer_d = TW'(HOLD_CYCLES - 1);
                    state_d = S_SHOW;
                end
            end
            S_SHOW: begin
                if (ack_w || (timer_q == '0)) begin
                    timer_d = TW'(GAP_CYCLES - 1);
                    state_d = S_GAP;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            S_GAP: begin
                if (timer_q == '0) state_d = S_IDLE;
                else               timer_d = timer_q - 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // An ack blanks the output on the same edge that leaves SHOW.
    assign kbd_out_d = ((state_q == S_SHOW) && !ack_w) ? cur_q : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            timer_q   <= '0;
            cur_q     <= '0;
            kbd_out_q <= '0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cur_q     <= cur_d;
            kbd_out_q <= kbd_out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hack_kbd_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_hack_kbd_controller
// Description : Randomized self-checking bench against a key-schedule model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hack_kbd_controller;
    localparam int DEPTH = 4;
    localparam int HOLD  = 8;
    localparam int GAPC  = 3;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    hack_kbd_controller_if #(.DEPTH(DEPTH)) bus ();

    hack_kbd_controller #(
        .DEPTH       (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAPC)
    ) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    // Model: buffered keys plus the edge window during which a popped key is visible.
    logic [15:0] mq [$];
    logic [15:0] show_code = 16'h0;
    longint      n         = 0;
    longint      next_pop  = 0;
    longint      show_from = 0;
    longint      show_to   = -1;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s edge=%0d observed=%h expected=%h", tag, n, obs, exp);
        end
    endtask

    task automatic step(input bit rst_n, input bit valid, input bit press,
                        input logic [15:0] code, input logic [15:0] addr, input bit wr);
        bit          ready;
        logic [15:0] exp_kbd;
        reset        = rst_n;
        bus.ev_valid = valid;
        bus.ev_press = press;
        bus.ev_code  = code;
        bus.addressM = addr;
        bus.writeM   = wr;
        @(posedge clock);
        exp_kbd = 16'h0;
        if (!rst_n) begin
            mq.delete();
            show_from = 0;
            show_to   = -1;
            next_pop  = 0;
        end else begin
            ready = (mq.size() != DEPTH);
`ifdef KBD_ACK_EN
            if (wr && addr == 16'h6000 && n >= show_from && n <= show_to) begin
                show_to  = n - 1;
                next_pop = n + GAPC + 1;
            end
`endif
            if (n >= show_from && n <= show_to) exp_kbd = show_code;
            if (mq.size() > 0 && n >= next_pop) begin
                show_code = mq.pop_front();
                show_from = n + 1;
                show_to   = n + HOLD;
                next_pop  = n + HOLD + GAPC + 1;
            end
            if (valid && ready && press && code != 16'h0) mq.push_back(code);
        end
        #1;
        check_val("kbd_out", bus.kbd_out, exp_kbd);
        check_val("fifo_level", 16'(bus.fifo_level), 16'(mq.size()));
        check_val("ev_ready", 16'(bus.ev_ready), 16'(mq.size() != DEPTH));
        n++;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1, 0, 0, 16'h0, 16'h0, 0);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(0, 0, 0, 16'h0, 16'h0, 0);

        step(1, 1, 1, 16'h0041, 16'h0, 0);
        idle(20);
        step(1, 1, 0, 16'h0041, 16'h0, 0);
        step(1, 1, 1, 16'h0000, 16'h0, 0);
        idle(3);

        for (int k = 0; k < 6; k++) step(1, 1, 1, 16'(16'h0041 + k), 16'h0, 0);
        idle(70);

        step(1, 1, 1, 16'h0051, 16'h0, 0);
        for (int k = 0; k < 4; k++) step(1, 1, 1, 16'(16'h0052 + k), 16'h0, 0);
        step(0, 0, 0, 16'h0, 16'h0, 0);
        idle(4);

        step(1, 1, 1, 16'h0061, 16'h0, 0);
        step(1, 1, 1, 16'h0062, 16'h0, 0);
        idle(3);
        step(1, 0, 0, 16'h0, 16'h6001, 1);
        step(1, 0, 0, 16'h0, 16'h6000, 1);
        idle(30);

        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 700; i++) begin
                int          vpct;
                bit          v, pr, wr, rn;
                logic [15:0] code, addr;
                vpct = (p == 0) ? 5 : (p == 1) ? 80 : 30;
                v    = ($urandom_range(0, 99) < vpct);
                pr   = (p == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                code = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'hFFFF));
                wr   = (p >= 2) && ($urandom_range(0, 15) == 0);
                case ($urandom_range(0, 2))
                    0:       addr = 16'h6000;
                    1:       addr = 16'h6001;
                    default: addr = 16'($urandom);
                endcase
                rn = !((p == 3) && ($urandom_range(0, 199) == 0));
                step(rn, v, pr, code, addr, wr);
            end
        end

        idle(40);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
